uart_rxd: RTL and testbench
===========================

// Module: uart_rxd
// PURPOSE
//  Asynchronous serial receiver, 8N1, LSB first; the receive counterpart of TXD on the floppy CPU UART.
//  Two-flop input synchroniser and mid-bit sampling feed a one-byte holding register.
//  The holding register has ready, framing-error and overrun flags.
//  The floppy 6502 reads the byte at IOBASE+PORT_RXD and the flags through the status output.
// PARAMETERS
//  CLKS_PER_BIT  208  clk cycles per bit (24 MHz / 115200); must be >= 4; half-bit = CLKS_PER_BIT/2, truncated
// PORTS
//  clk      in   1  single system clock; all state changes on posedge clk
//  reset    in   1  asynchronous, active-high reset
//  rxd      in   1  serial line, idle high, asynchronous to clk
//  rd       in   1  read strobe, one clk wide (CPU read of the data port); acknowledges the held byte and flags
//  q        out  8  holding register: last accepted byte
//  rdy      out  1  1 = unread byte in q
//  ferr     out  1  1 = a frame with stop bit 0 was seen since the last rd
//  ovr      out  1  1 = a complete frame was dropped because rdy was still set
//  status   out  8  {5'b0, ovr, ferr, rdy}, for the CPU input-port mux
//  busy     out  1  1 while the FSM is not in IDLE
// BEHAVIOUR
//  Reset:
//   - q=0, rdy=ferr=ovr=0, busy=0, FSM=IDLE.
//   - Both synchroniser flops are set to 1, so no false start is detected after reset.
//   - Reset mid-frame abandons the frame with no flag change beyond the reset values.
//  Synchronised line rs = rxd delayed 2 clk. One down-counter cnt and a 3-bit bit index idx.
//  FSM states and transitions:
//   - IDLE: when rs=0, load cnt=CLKS_PER_BIT/2-1 and go to START.
//   - START: at cnt=0:
//     - if rs=0, load cnt=CLKS_PER_BIT-1, set idx=0 and go to DATA;
//     - if rs=1, treat it as a glitch and go to IDLE with no flags.
//   - DATA: at cnt=0, shift rs into sh[idx], which places the first received bit in bit0.
//     - Reload cnt=CLKS_PER_BIT-1.
//     - If idx=7, go to STOP; otherwise increment idx.
//   - STOP: at cnt=0, sample rs:
//     - rs=1 and rdy=0: q<=sh and rdy<=1 on that same edge; go to IDLE.
//     - rs=1 and rdy=1 and no rd this cycle: ovr<=1; q is unchanged and the new byte is discarded; go to IDLE.
//     - rs=0: ferr<=1; q and rdy are unchanged; go to BREAK.
//   - BREAK: stay until rs=1, then go to IDLE. A held-low line yields exactly one ferr, not repeated frames.
//  Timing:
//   - Stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk after the first clk with rs=0.
//   - rdy is visible the clk after that sample.
//   - The next start edge is accepted on the clk after the return to IDLE.
//  Read handshake:
//   - rd clears rdy, ferr and ovr on the next edge.
//   - q holds its value until a new byte is accepted.
//   - rd while rdy=0 clears the error flags only.
//  Simultaneous events:
//   - rd in the same cycle as a good stop sample: the new byte is loaded, rdy stays 1, ovr is not set.
//   - rd in the same cycle as a bad stop sample: ferr ends at 1, because the new error wins.
//  Other rules:
//   - Flags are sticky until rd or reset.
//   - busy = (FSM != IDLE).
// TESTING (bench uses CLKS_PER_BIT=16)
//  1. Send 0x55 then 0xA3 with rd pulsed after each rdy -> q=0x55 then 0xA3; rdy rises 153+2 clk after the start edge; ferr=ovr=0.
//  2. Drive a 5-clk low pulse on idle rxd -> FSM returns to IDLE; rdy, ferr, ovr stay 0; busy drops within 8 clk.
//  3. Send 0x41 with stop bit low, then release the line -> ferr=1, rdy=0, q unchanged; next good frame 0x42 gives rdy=1, q=0x42, ferr still 1 until rd.
//  4. Send 0x11 and 0x22 with no rd -> q=0x11, rdy=1, ovr=1; one rd gives rdy=ovr=0, q=0x11.
//  5. Assert rd exactly on the stop-sample cycle of 0x7E with rdy=1 -> q=0x7E, rdy=1, ovr=0.
//  6. Assert reset in the middle of DATA of 0xFF -> all outputs 0 asynchronously; a following 0x0F frame is received correctly.

Source files
------------

// File: rtl/uart_rxd.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling, one-byte holding register with rdy/ferr/ovr.
// rdy rises the cycle after the stop sample; a good frame arriving while rdy is held and no rd is pending is dropped and sets ovr.
module uart_rxd #(
  parameter int CLKS_PER_BIT = 208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] q,
  output logic       rdy,
  output logic       ferr,
  output logic       ovr,
  output logic [7:0] status,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          s1, s2;
  logic          rs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  assign rs     = s2;
  assign busy   = (state != IDLE);
  assign status = {5'b0, ovr, ferr, rdy};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Synchroniser resets to the idle level so reset release never looks like a start bit
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      q     <= '0;
      rdy   <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      s1 <= rxd;
      s2 <= s1;

      if (rd) begin
        rdy  <= 1'b0;
        ferr <= 1'b0;
        ovr  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rs) begin
            cnt   <= HALF_LD;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rs) begin
              cnt   <= BIT_LD;
              idx   <= '0;
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            sh[idx] <= rs;
            cnt     <= BIT_LD;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rs) begin
              // A read on the same edge frees the register, so the new byte is taken, not dropped
              if (!rdy || rd) begin
                q   <= sh;
                rdy <= 1'b1;
              end else begin
                ovr <= 1'b1;
              end
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= BRK;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BRK: begin
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rxd.sv
// Directed plus randomized frames against a holding-register model of the receiver.
module tb_uart_rxd;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] q;
  logic       rdy, ferr, ovr, busy;
  logic [7:0] status;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_cyc = -1;
  logic rdy_q = 1'b0;

  // reference model of the CPU-visible register and flags
  logic [7:0] m_q = 8'h00;
  logic       m_rdy = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  uart_rxd #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd(rd),
    .q(q), .rdy(rdy), .ferr(ferr), .ovr(ovr), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rdy && !rdy_q) rise_cyc = cyc;
    rdy_q = rdy;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, int'(q), int'(m_q));
    check({tag, ".rdy"}, int'(rdy), int'(m_rdy));
    check({tag, ".ferr"}, int'(ferr), int'(m_ferr));
    check({tag, ".ovr"}, int'(ovr), int'(m_ovr));
    check({tag, ".status"}, int'(status), int'({5'b0, m_ovr, m_ferr, m_rdy}));
    check({tag, ".busy"}, int'(busy), 0);
  endtask

  // Frame outcome from the register rules: good stop loads if free (or read same cycle), else overrun
  task automatic model_frame(input logic [7:0] b, input logic good, input logic rd_same);
    if (good) begin
      if (!m_rdy || rd_same) begin
        m_q = b;
        m_rdy = 1'b1;
        if (rd_same) begin m_ferr = 1'b0; m_ovr = 1'b0; end
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (rd_same) begin m_rdy = 1'b0; m_ovr = 1'b0; end
      m_ferr = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    @(negedge clk);
    t0 = cyc + 1;
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (C) @(negedge clk);
    end
    rxd = stop_val;
    repeat (C) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rgood, rread;

    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all("post_reset");

    // 1: two good frames, rdy latency measured from the first low sample of rxd
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1, 1'b0);
    check("t1_lat55", rise_cyc - t0 + 1, 155);
    check_all("t1_55");
    do_rd();
    send_frame(8'hA3, 1'b1);
    model_frame(8'hA3, 1'b1, 1'b0);
    check("t1_latA3", rise_cyc - t0 + 1, 155);
    check_all("t1_A3");
    do_rd();
    check_all("t1_rd");

    // 2: short low glitch is rejected in START
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_busy_hi", int'(busy), 1);
    @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    check_all("t2_glitch");

    // 3: framing error, then a good frame keeps ferr until read
    send_frame(8'h41, 1'b0);
    model_frame(8'h41, 1'b0, 1'b0);
    check_all("t3_ferr");
    send_frame(8'h42, 1'b1);
    model_frame(8'h42, 1'b1, 1'b0);
    check_all("t3_42");
    do_rd();
    check_all("t3_rd");

    // 4: overrun
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    check_all("t4_ovr");
    do_rd();
    check_all("t4_rd");

    // 5: rd lands on the stop-sample edge while rdy is held
    send_frame(8'h33, 1'b1);
    model_frame(8'h33, 1'b1, 1'b0);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    model_frame(8'h7E, 1'b1, 1'b1);
    check_all("t5_rd_stop");
    do_rd();

    // 6: asynchronous reset in the middle of DATA
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(negedge clk);
        repeat (60) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_q = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_all("t6_in_reset");
        @(negedge clk);
        reset = 1'b0;
      end
    join
    check_all("t6_after");
    send_frame(8'h0F, 1'b1);
    model_frame(8'h0F, 1'b1, 1'b0);
    check_all("t6_0F");
    do_rd();

    // randomized frames, stop bits and read patterns
    for (int n = 0; n < 8; n++) begin
      rb    = 8'($urandom);
      rgood = ($urandom_range(0, 3) != 0);
      rread = 1'($urandom_range(0, 1));
      send_frame(rb, rgood);
      model_frame(rb, rgood, 1'b0);
      check_all($sformatf("rand%0d", n));
      if (rread) begin
        do_rd();
        check_all($sformatf("rand%0d_rd", n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
